pwm_multi_breath: RTL and testbench

//  N-channel LED PWM generator with per-channel mode: off, fixed duty, triangle "breathing", sawtooth ramp.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_breath_ch.sv | 101 ++++++++++
 rtl/pwm_multi_breath.sv | 85 ++++++++
 tb/tb_pwm_multi_breath.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared mode and direction constants for the multi-channel breathing PWM.
package pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_FIX  = 2'd1,
    MODE_BRTH = 2'd2,
    MODE_RAMP = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_breath_ch.sv
// One PWM channel: latches mode/duty at period boundaries, runs the
// breathing/ramp duty engine and registers the compare output.
module pwm_breath_ch
  import pwm_pkg::*;
#(
  parameter int PWM_W = 10,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             bnd_i,
  input  logic             step_i,
  input  logic [PWM_W-1:0] cnt_i,
  input  logic [1:0]       mode_i,
  input  logic [PWM_W-1:0] duty_cfg_i,
  output logic             pwm_o,
  output logic [PWM_W-1:0] duty_o
);

  localparam logic        [PWM_W:0] DMAX   = {1'b0, {PWM_W{1'b1}}};
  localparam logic        [PWM_W:0] STEP_X = (PWM_W + 1)'(STEP);
  localparam logic signed [PWM_W:0] STEP_S = STEP_X;

  mode_e                   mode_q, mode_d;
  dir_e                    dir_q, dir_d;
  logic        [PWM_W-1:0] duty_q, duty_d;
  logic                    pwm_q;
  logic        [PWM_W:0]   up_sum;
  logic signed [PWM_W:0]   dn_dif;

  // Upward step saturates at full scale; the extra bit catches overflow.
  function automatic logic [PWM_W-1:0] sat_hi(input logic [PWM_W:0] s);
    return (s >= DMAX) ? DMAX[PWM_W-1:0] : s[PWM_W-1:0];
  endfunction

  // Downward step clamps at zero; a non-positive result never wraps.
  function automatic logic [PWM_W-1:0] sat_lo(input logic signed [PWM_W:0] d);
    return (d <= 0) ? '0 : d[PWM_W-1:0];
  endfunction

  // Next mode/duty/direction, evaluated only at a period boundary.
  always_comb begin
    up_sum = {1'b0, duty_q} + STEP_X;
    dn_dif = $signed({1'b0, duty_q}) - STEP_S;
    mode_d = mode_q;
    dir_d  = dir_q;
    duty_d = duty_q;
    if (bnd_i) begin
      mode_d = mode_e'(mode_i);
      if ((mode_d != mode_q) && ((mode_d == MODE_BRTH) || (mode_d == MODE_RAMP))) begin
        duty_d = duty_cfg_i;
        dir_d  = DIR_UP;
      end else begin
        case (mode_d)
          MODE_OFF:  duty_d = '0;
          MODE_FIX:  duty_d = duty_cfg_i;
          MODE_BRTH: begin
            if (step_i) begin
              if (dir_q == DIR_UP) begin
                duty_d = sat_hi(up_sum);
                if (up_sum >= DMAX) dir_d = DIR_DN;
              end else begin
                duty_d = sat_lo(dn_dif);
                if (dn_dif <= 0) dir_d = DIR_UP;
              end
            end
          end
          MODE_RAMP: begin
            if (step_i) duty_d = up_sum[PWM_W-1:0];
          end
          default: duty_d = duty_q;
        endcase
      end
    end
  end

  // Channel state and registered compare output; cleared by reset or disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      dir_q  <= DIR_UP;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else if (clr_i) begin
      mode_q <= MODE_OFF;
      dir_q  <= DIR_UP;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      duty_q <= duty_d;
      pwm_q  <= (cnt_i < duty_q);
    end
  end

  assign pwm_o  = pwm_q;
  assign duty_o = duty_q;

endmodule

// File: rtl/pwm_multi_breath.sv
// N-channel LED PWM with shared prescaler/period/ramp counters and
// per-channel off/fixed/breathing/ramp duty engines.
module pwm_multi_breath
  import pwm_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int PWM_W    = 10,
  parameter int PRESC_W  = 4,
  parameter int RAMP_DIV = 8,
  parameter int STEP     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [PWM_W*N_CH-1:0] duty_cfg,
  output logic [N_CH-1:0]       pwm_out,
  output logic [PWM_W*N_CH-1:0] duty_cur,
  output logic                  period_stb
);

  localparam int              RC_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic [RC_W-1:0]    ramp_q, ramp_d;
  logic               stb_q;
  logic               presc_wrap;
  logic               bnd;
  logic               step;

  assign presc_wrap = &presc_q;
  assign bnd        = en && presc_wrap && (&cnt_q);
  assign step       = bnd && (ramp_q == RC_LAST);

  // Counter next-state: slot advances on prescaler wrap, ramp_cnt per period.
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    cnt_d   = presc_wrap ? (cnt_q + PWM_W'(1)) : cnt_q;
    ramp_d  = ramp_q;
    if (bnd) ramp_d = (ramp_q == RC_LAST) ? '0 : (ramp_q + RC_W'(1));
  end

  // Shared counters and the registered period strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      ramp_q  <= '0;
      stb_q   <= 1'b0;
    end else if (!en) begin
      presc_q <= '0;
      cnt_q   <= '0;
      ramp_q  <= '0;
      stb_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ramp_q  <= ramp_d;
      stb_q   <= bnd;
    end
  end

  assign period_stb = stb_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_breath_ch #(
      .PWM_W (PWM_W),
      .STEP  (STEP)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (~en),
      .bnd_i      (bnd),
      .step_i     (step),
      .cnt_i      (cnt_q),
      .mode_i     (mode[2*i +: 2]),
      .duty_cfg_i (duty_cfg[PWM_W*i +: PWM_W]),
      .pwm_o      (pwm_out[i]),
      .duty_o     (duty_cur[PWM_W*i +: PWM_W])
    );
  end

endmodule

// File: tb/tb_pwm_multi_breath.sv
// Bench for pwm_multi_breath: a time-based behavioural model runs alongside
// directed phases and a randomized phase; outputs compared every negedge.
module tb_pwm_multi_breath;

  localparam int N_CH     = 2;
  localparam int PWM_W    = 4;
  localparam int PRESC_W  = 1;
  localparam int RAMP_DIV = 2;
  localparam int STEP     = 1;
  localparam int SLOT     = 2;
  localparam int PER      = 32;
  localparam int DMAX     = 15;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [2*N_CH-1:0]     mode;
  logic [PWM_W*N_CH-1:0] duty_cfg;
  logic [N_CH-1:0]       pwm_out;
  logic [PWM_W*N_CH-1:0] duty_cur;
  logic                  period_stb;

  int checks = 0;
  int errors = 0;
  bit mon    = 1'b0;

  // model state: clocks since clear, periods since clear, per-channel duty engine
  int   m_t, m_per;
  int   m_duty [N_CH];
  int   m_mact [N_CH];
  bit   m_dn   [N_CH];
  logic [N_CH-1:0] m_pwm;
  bit   m_stb;

  int prev0, prev1, wrap0, pk1, bt1;

  pwm_multi_breath #(
    .N_CH(N_CH), .PWM_W(PWM_W), .PRESC_W(PRESC_W), .RAMP_DIV(RAMP_DIV), .STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .duty_cfg(duty_cfg),
    .pwm_out(pwm_out), .duty_cur(duty_cur), .period_stb(period_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_t = 0;
    m_per = 0;
    m_pwm = '0;
    m_stb = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      m_duty[i] = 0;
      m_mact[i] = 0;
      m_dn[i]   = 1'b0;
    end
  endfunction

  function automatic void model_bnd(input int i, input int m, input int cfg, input bit stp);
    int d, v;
    d = m_duty[i];
    if (m != m_mact[i] && m >= 2) begin
      d = cfg;
      m_dn[i] = 1'b0;
    end else begin
      case (m)
        0: d = 0;
        1: d = cfg;
        2: if (stp) begin
          if (!m_dn[i]) begin
            v = d + STEP;
            if (v >= DMAX) begin v = DMAX; m_dn[i] = 1'b1; end
          end else begin
            v = d - STEP;
            if (v <= 0) begin v = 0; m_dn[i] = 1'b0; end
          end
          d = v;
        end
        default: if (stp) d = (d + STEP) % (DMAX + 1);
      endcase
    end
    m_duty[i] = d;
    m_mact[i] = m;
  endfunction

  // reference model, advanced on every active clock edge
  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || !en) model_clear();
      else begin
        int pos;
        bit stp;
        pos = m_t % PER;
        for (int i = 0; i < N_CH; i++) m_pwm[i] = ((pos / SLOT) < m_duty[i]);
        m_stb = (pos == PER - 1);
        if (m_stb) begin
          stp = ((m_per % RAMP_DIV) == RAMP_DIV - 1);
          for (int i = 0; i < N_CH; i++)
            model_bnd(i, int'(mode[2*i +: 2]), int'(duty_cfg[PWM_W*i +: PWM_W]), stp);
          m_per++;
        end
        m_t++;
      end
    end
  end

  // continuous compare against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (mon) begin
        logic [7:0] ed;
        ed = {m_duty[1][3:0], m_duty[0][3:0]};
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("duty_cur", 32'(duty_cur), 32'(ed));
        check("period_stb", 32'(period_stb), 32'(m_stb));
      end
    end
  end

  // count high clocks of one full period following a strobe; optional mid-period cfg0 change
  task automatic meas(input int chg_at, input logic [3:0] new0, output int h0, output int h1, output int ns);
    int k;
    k = 0; h0 = 0; h1 = 0; ns = 0;
    while (!period_stb && k < 4 * PER) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4 * PER) check("stb_wait", 0, 1);
    for (int j = 0; j < PER; j++) begin
      @(negedge clk);
      if (j == chg_at) duty_cfg[3:0] = new0;
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      ns += int'(period_stb);
    end
  endtask

  task automatic run_cyc(input int n);
    int c0, c1;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      c0 = int'(duty_cur[3:0]);
      c1 = int'(duty_cur[7:4]);
      if (prev0 == 15 && c0 == 0) wrap0++;
      if (prev1 == 15 && c1 == 14) pk1++;
      if (prev1 == 1 && c1 == 0) bt1++;
      prev0 = c0;
      prev1 = c1;
    end
  endtask

  initial begin
    int h0, h1, ns, k;
    rst_n = 1'b0; en = 1'b0; mode = '0; duty_cfg = '0;
    prev0 = 0; prev1 = 0; wrap0 = 0; pk1 = 0; bt1 = 0;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_duty", 32'(duty_cur), 0);
    check("rst_stb", 32'(period_stb), 0);
    mon = 1'b1;

    // fixed duty on ch0, ch1 off
    rst_n = 1'b1; en = 1'b1; mode = 4'b0001; duty_cfg = 8'h05;
    meas(-1, 4'd0, h0, h1, ns);
    check("fix5_hi", 32'(h0), 10);
    check("off_hi", 32'(h1), 0);
    check("stb_count", 32'(ns), 1);

    // mid-period cfg change only lands at the next boundary
    meas(6, 4'd12, h0, h1, ns);
    check("glitch_cur", 32'(h0), 10);
    meas(-1, 4'd0, h0, h1, ns);
    check("glitch_next", 32'(h0), 24);

    duty_cfg[3:0] = 4'd0;
    meas(-1, 4'd0, h0, h1, ns);
    meas(-1, 4'd0, h0, h1, ns);
    check("fix0_hi", 32'(h0), 0);
    duty_cfg[3:0] = 4'd15;
    meas(-1, 4'd0, h0, h1, ns);
    meas(-1, 4'd0, h0, h1, ns);
    check("fix15_hi", 32'(h0), 30);
    duty_cfg[3:0] = 4'd8;
    meas(-1, 4'd0, h0, h1, ns);
    meas(-1, 4'd0, h0, h1, ns);
    check("fix8_hi", 32'(h0), 16);
    check("indep_ch1", 32'(h1), 0);
    check("stb_once", 32'(ns), 1);

    // one-clock disable clears everything at the next edge
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_duty", 32'(duty_cur), 0);
    check("en_pwm", 32'(pwm_out), 0);
    en = 1'b1;

    // breathing on ch1 from 13, then from 0 across both turning points
    mode = 4'b1001; duty_cfg = 8'hD8;
    run_cyc(40 * PER);
    check("brth13_peak", 32'(pk1 > 0), 1);
    mode = 4'b0001;
    run_cyc(2 * PER);
    pk1 = 0; bt1 = 0;
    mode = 4'b1001; duty_cfg = 8'h08;
    run_cyc(70 * PER);
    check("brth0_peak", 32'(pk1 > 0), 1);
    check("brth0_bottom", 32'(bt1 > 0), 1);

    // sawtooth on ch0 from 14, must wrap 15 -> 0
    mode = 4'b1011; duty_cfg = 8'h0E;
    run_cyc(12 * PER);
    check("ramp_wrap", 32'(wrap0 > 0), 1);

    // randomized modes, duties and disable pulses
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk);
      en = 1'b1;
      if ($urandom_range(39, 0) == 0) mode = 4'($urandom);
      if ($urandom_range(29, 0) == 0) duty_cfg = 8'($urandom);
      if ($urandom_range(499, 0) == 0) en = 1'b0;
    end
    @(negedge clk);
    en = 1'b1;

    // asynchronous reset while outputs are high
    mode = 4'b0101; duty_cfg = 8'hFF;
    run_cyc(3 * PER);
    k = 0;
    while (pwm_out[0] !== 1'b1 && k < 4 * PER) begin
      @(negedge clk);
      k++;
    end
    check("pre_rst_high", 32'(pwm_out[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm_out), 0);
    check("arst_duty", 32'(duty_cur), 0);
    check("arst_stb", 32'(period_stb), 0);
    @(negedge clk);
    rst_n = 1'b1;
    meas(-1, 4'd0, h0, h1, ns);
    meas(-1, 4'd0, h0, h1, ns);
    check("post_rst_hi0", 32'(h0), 30);
    check("post_rst_hi1", 32'(h1), 30);

    mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
